// File: rtl/ram_pkg.sv
// Shared types and address-map constants for the banked SPRAM memory.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        RESP
    } state_t;

    localparam int BANK_BYTES     = 65536;
    localparam int BANK_ADDR_LSB  = $clog2(BANK_BYTES);
    localparam int WORD_ADDR_BITS = BANK_ADDR_LSB - 2;

    // Each byte enable drives the two 4-bit write-enable nibbles of its byte.
    function automatic logic [7:0] nibble_mask(input logic [3:0] byte_mask);
        logic [7:0] nibbles;
        nibbles = '0;
        for (int i = 0; i < 4; i++) begin
            nibbles[2*i +: 2] = {2{byte_mask[i]}};
        end
        return nibbles;
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural stand-in for the iCE40 UP 16Kx16 single-port RAM primitive;
// leave this file out when the vendor library supplies SB_SPRAM256KA.
module SB_SPRAM256KA (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] mem [16384];

    // NOTE: the storage array has no reset branch; RAM contents are never
    // cleared by reset, and <= keeps every clocked update race-free.
    always_ff @(posedge CLOCK) begin
        if (CHIPSELECT && !SLEEP && !STANDBY && POWEROFF) begin
            if (WREN) begin
                for (int i = 0; i < 4; i++) begin
                    if (MASKWREN[i]) begin
                        mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
                    end
                end
            end else begin
                DATAOUT <= mem[ADDRESS];
            end
        end
    end

endmodule

// File: rtl/spram_bank.sv
// One 64 KiB bank: two 16-bit SPRAMs side by side forming a 32-bit word.
module spram_bank
    import ram_pkg::*;
(
    input  logic                      clk,
    input  logic [WORD_ADDR_BITS-1:0] address,
    input  logic                      chipselect,
    input  logic                      wren,
    input  logic                      sleep,
    input  logic [31:0]               write_value,
    input  logic [3:0]                write_mask,
    output logic [31:0]               read_value
);

    logic [7:0] nibble_en;

    assign nibble_en = nibble_mask(write_mask);

    SB_SPRAM256KA u_lo (
        .ADDRESS    (address),
        .DATAIN     (write_value[15:0]),
        .MASKWREN   (nibble_en[3:0]),
        .WREN       (wren),
        .CHIPSELECT (chipselect),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (sleep),
        .POWEROFF   (1'b1),
        .DATAOUT    (read_value[15:0])
    );

    SB_SPRAM256KA u_hi (
        .ADDRESS    (address),
        .DATAIN     (write_value[31:16]),
        .MASKWREN   (nibble_en[7:4]),
        .WREN       (wren),
        .CHIPSELECT (chipselect),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (sleep),
        .POWEROFF   (1'b1),
        .DATAOUT    (read_value[31:16])
    );

endmodule

// File: rtl/ram_banked.sv
// Banked SPRAM memory on the CPU word bus: request/response FSM, bank decode,
// out-of-range error. Define RAM_SLEEP_EN to put idle banks to sleep.
module ram_banked
    import ram_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int SLEEP_IDLE  = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        error_out
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    state_t                    state_q, state_d;
    logic [BANK_BITS-1:0]      bank_idx, bank_q;
    logic                      bank_valid, err_q, wr_q, target_asleep, wake_done;
    logic [NUM_BANKS-1:0]      bank_hit, bank_cs, bank_sleep;
    logic [31:0]               bank_rdata [NUM_BANKS];
    logic [WORD_ADDR_BITS-1:0] word_addr;
    logic                      unused_addr;

    assign word_addr   = address_in[WORD_ADDR_BITS+1:2];
    assign unused_addr = ^{address_in[31:BANK_ADDR_LSB], address_in[1:0]};

    if (NUM_BANKS == 1) begin : g_single
        assign bank_idx   = '0;
        assign bank_valid = 1'b1;
    end else begin : g_multi
        assign bank_idx   = address_in[BANK_ADDR_LSB +: BANK_BITS];
        assign bank_valid = int'(bank_idx) < NUM_BANKS;
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // latch behind.
    always_comb begin
        bank_hit = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_hit[b] = bank_valid && (int'(bank_idx) == b);
        end
    end

    assign target_asleep = |(bank_hit & bank_sleep);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bank_q  <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sel_in) begin
                bank_q <= bank_idx;
                err_q  <= !bank_valid;
                wr_q   <= |write_mask_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_in) begin
                    state_d = (bank_valid && target_asleep) ? WAKE : RESP;
                end
            end
            WAKE:    if (wake_done) state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Chip selects fire only from IDLE and are gated by reset, so an access
    // is never repeated and a write caught by reset is never committed.
    always_comb begin
        bank_cs        = '0;
        ready_out      = 1'b0;
        error_out      = 1'b0;
        read_value_out = '0;
        case (state_q)
            IDLE: begin
                if (reset && sel_in && !target_asleep) begin
                    bank_cs = bank_hit;
                end
            end
            RESP: begin
                ready_out = 1'b1;
                error_out = err_q;
                if (!err_q && !wr_q) begin
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        if (int'(bank_q) == b) read_value_out = bank_rdata[b];
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef RAM_SLEEP_EN
    localparam int CNT_W  = $clog2(SLEEP_IDLE + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    logic [NUM_BANKS-1:0][CNT_W-1:0] idle_cnt_q;
    logic [NUM_BANKS-1:0]            bank_touch;
    logic [WAKE_W-1:0]               wake_cnt_q;

    // A bank stays awake while it is being requested or woken.
    always_comb begin
        bank_touch = '0;
        bank_sleep = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_touch[b] = (state_q == IDLE && sel_in && bank_hit[b]) ||
                            (state_q == WAKE && int'(bank_q) == b);
            bank_sleep[b] = idle_cnt_q[b] == CNT_W'(SLEEP_IDLE);
        end
    end

    assign wake_done = wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_touch[b]) begin
                    idle_cnt_q[b] <= '0;
                end else if (!bank_sleep[b]) begin
                    idle_cnt_q[b] <= idle_cnt_q[b] + 1'b1;
                end
            end
            wake_cnt_q <= (state_q == WAKE) ? wake_cnt_q + 1'b1 : '0;
        end
    end
`else
    localparam int unused_sleep_cfg = SLEEP_IDLE + WAKE_CYCLES;

    assign bank_sleep = '0;
    assign wake_done  = 1'b1;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        spram_bank u_bank (
            .clk         (clk),
            .address     (word_addr),
            .chipselect  (bank_cs[b]),
            .wren        (|write_mask_in),
            .sleep       (bank_sleep[b]),
            .write_value (write_value_in),
            .write_mask  (write_mask_in),
            .read_value  (bank_rdata[b])
        );
    end

endmodule
